ibex_div_iter: RTL and testbench



---
 rtl/ibex_div_iter_pkg.sv | 32 +++
 rtl/ibex_div_step.sv | 31 +++
 rtl/ibex_div_iter.sv | 187 ++++++++++++++++++
 tb/tb_ibex_div_iter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_div_iter_pkg.sv
// ----------------------------------------------------------------------------
// ibex_div_iter_pkg
// Shared types and helpers for the iterative divider.
//   div_op_e    : operation encoding on op_i (DIV=0, DIVU=1, REM=2, REMU=3)
//   div_state_e : divider control states
//   op_is_signed / op_is_rem : decode helpers used at accept and in FIX
// ----------------------------------------------------------------------------
package ibex_div_iter_pkg;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'd0,
        DIV_OP_DIVU = 2'd1,
        DIV_OP_REM  = 2'd2,
        DIV_OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    function automatic logic op_is_signed(input div_op_e op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/ibex_div_step.sv
// ----------------------------------------------------------------------------
// ibex_div_step
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, subtract the divisor if it fits.
//   rem_i          [Width:0]   partial remainder in
//   divisor_i      [Width-1:0] divisor magnitude
//   dividend_bit_i             next dividend bit (MSB first)
//   rem_o          [Width:0]   partial remainder out
//   quot_bit_o                 quotient bit produced by this step
// ----------------------------------------------------------------------------
module ibex_div_step #(
    parameter int unsigned Width = 32
) (
    input  logic [Width:0]   rem_i,
    input  logic [Width-1:0] divisor_i,
    input  logic             dividend_bit_i,
    output logic [Width:0]   rem_o,
    output logic             quot_bit_o
);

    logic [Width:0] shifted;
    logic [Width:0] diff;

    assign shifted = {rem_i[Width-1:0], dividend_bit_i};
    assign diff    = shifted - {1'b0, divisor_i};

    // A set top bit means the true shifted value exceeds any Width-bit divisor.
    assign quot_bit_o = rem_i[Width] | (shifted >= {1'b0, divisor_i});
    assign rem_o      = quot_bit_o ? diff : shifted;

endmodule

// File: rtl/ibex_div_iter.sv
// ----------------------------------------------------------------------------
// ibex_div_iter
// Iterative signed/unsigned restoring divider with valid/ready handshakes.
// BitsPerCycle quotient bits are retired per CALC cycle.
// Optional macro IBEX_DIV_EARLY_TERM_EN: when defined, |a| < |b| finishes
// straight from IDLE to DONE (quotient 0, remainder = dividend).
//   clk_i, rst_ni        clock, synchronous active-low reset
//   in_valid_i/in_ready_o request handshake (ready only in IDLE)
//   op_i, op_a_i, op_b_i operation, dividend, divisor
//   kill_i               flush any in-flight operation
//   out_valid_o/out_ready_i result handshake
//   result_o             quotient or remainder
//   busy_o               state != IDLE
// ----------------------------------------------------------------------------
module ibex_div_iter
    import ibex_div_iter_pkg::*;
#(
    parameter int unsigned Width        = 32,
    parameter int unsigned BitsPerCycle = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  div_op_e          op_i,
    input  logic [Width-1:0] op_a_i,
    input  logic [Width-1:0] op_b_i,
    input  logic             kill_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] result_o,
    output logic             busy_o
);

    localparam int unsigned      NumIter = Width / BitsPerCycle;
    localparam int unsigned      CntW    = $clog2(NumIter);
    localparam logic [CntW-1:0]  CntInit = CntW'(NumIter - 1);
    localparam logic [Width-1:0] MinNeg  = {1'b1, {(Width-1){1'b0}}};

    if ((BitsPerCycle != 1 && BitsPerCycle != 2) || (Width % BitsPerCycle) != 0 ||
        (Width % 2) != 0 || Width < 8) begin : g_param_check
        $error("ibex_div_iter: illegal Width/BitsPerCycle combination");
    end

    div_state_e       state_q, state_d;
    div_op_e          op_q, op_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic [Width:0]   rem_q, rem_d;
    logic [Width-1:0] quot_q, quot_d;
    logic [Width-1:0] divisor_q, divisor_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [Width-1:0] result_q, result_d;

    // Accept-time operand conditioning.
    logic             a_sign, b_sign;
    logic [Width-1:0] a_abs, b_abs;
    logic             div_zero, sgn_ovf, accept;
    logic [Width-1:0] fix_sel;

    assign a_sign   = op_is_signed(op_i) & op_a_i[Width-1];
    assign b_sign   = op_is_signed(op_i) & op_b_i[Width-1];
    assign a_abs    = a_sign ? -op_a_i : op_a_i;
    assign b_abs    = b_sign ? -op_b_i : op_b_i;
    assign div_zero = (op_b_i == '0);
    assign sgn_ovf  = op_is_signed(op_i) && (op_a_i == MinNeg) && (op_b_i == '1);
    assign accept   = in_valid_i & in_ready_o & ~kill_i;

    // Shift-subtract chain; step 0 consumes the current dividend MSB.
    logic [Width:0]          rem_chain [BitsPerCycle+1];
    logic [BitsPerCycle-1:0] quot_bits;

    assign rem_chain[0] = rem_q;

    for (genvar k = 0; k < BitsPerCycle; k++) begin : g_step
        ibex_div_step #(.Width(Width)) u_step (
            .rem_i         (rem_chain[k]),
            .divisor_i     (divisor_q),
            .dividend_bit_i(quot_q[Width-1-k]),
            .rem_o         (rem_chain[k+1]),
            .quot_bit_o    (quot_bits[BitsPerCycle-1-k])
        );
    end

    assign fix_sel = op_is_rem(op_q) ? rem_q[Width-1:0] : quot_q;

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through the
        // case statement can leave a signal unassigned and infer a latch.
        state_d    = state_q;
        op_d       = op_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        divisor_d  = divisor_q;
        cnt_d      = cnt_q;
        result_d   = result_q;

        if (kill_i) begin
            state_d = DIV_IDLE;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (accept) begin
                        op_d       = op_i;
                        divisor_d  = b_abs;
                        quot_d     = a_abs;
                        rem_d      = '0;
                        cnt_d      = CntInit;
                        neg_quot_d = a_sign ^ b_sign;
                        neg_rem_d  = a_sign;
                        state_d    = DIV_CALC;
                        if (div_zero) begin
                            result_d = op_is_rem(op_i) ? op_a_i : '1;
                            state_d  = DIV_DONE;
                        end else if (sgn_ovf) begin
                            result_d = op_is_rem(op_i) ? '0 : MinNeg;
                            state_d  = DIV_DONE;
                        end
`ifdef IBEX_DIV_EARLY_TERM_EN
                        else if (a_abs < b_abs) begin
                            result_d = op_is_rem(op_i) ? op_a_i : '0;
                            state_d  = DIV_DONE;
                        end
`endif
                    end
                end
                DIV_CALC: begin
                    rem_d  = rem_chain[BitsPerCycle];
                    quot_d = {quot_q[Width-1-BitsPerCycle:0], quot_bits};
                    if (cnt_q == '0) begin
                        state_d = DIV_FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                DIV_FIX: begin
                    if (op_is_signed(op_q) && (op_is_rem(op_q) ? neg_rem_q : neg_quot_q)) begin
                        result_d = -fix_sel;
                    end else begin
                        result_d = fix_sel;
                    end
                    state_d = DIV_DONE;
                end
                DIV_DONE: begin
                    if (out_ready_i) begin
                        state_d = DIV_IDLE;
                    end
                end
                default: state_d = DIV_IDLE;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of the others; reset is synchronous here.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= DIV_IDLE;
            op_q       <= DIV_OP_DIV;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            rem_q      <= '0;
            quot_q     <= '0;
            divisor_q  <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            divisor_q  <= divisor_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
        end
    end

    assign in_ready_o  = (state_q == DIV_IDLE);
    assign busy_o      = (state_q != DIV_IDLE);
    assign out_valid_o = (state_q == DIV_DONE);
    assign result_o    = result_q;

endmodule

// File: tb/tb_ibex_div_iter.sv
// ----------------------------------------------------------------------------
// tb_ibex_div_iter
// Drives two divider instances (BitsPerCycle = 1 and 2, Width = 32) from the
// same inputs and checks results and latencies against hand-computed values.
// ----------------------------------------------------------------------------
module tb_ibex_div_iter;
    import ibex_div_iter_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        in_valid_i;
    logic        kill_i;
    logic        out_ready_i;
    div_op_e     op_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;

    logic        in_ready1, out_valid1, busy1;
    logic [31:0] result1;
    logic        in_ready2, out_valid2, busy2;
    logic [31:0] result2;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ibex_div_iter #(.Width(32), .BitsPerCycle(1)) u_dut1 (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready1),
        .op_i       (op_i),
        .op_a_i     (op_a_i),
        .op_b_i     (op_b_i),
        .kill_i     (kill_i),
        .out_valid_o(out_valid1),
        .out_ready_i(out_ready_i),
        .result_o   (result1),
        .busy_o     (busy1)
    );

    ibex_div_iter #(.Width(32), .BitsPerCycle(2)) u_dut2 (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready2),
        .op_i       (op_i),
        .op_a_i     (op_a_i),
        .op_b_i     (op_b_i),
        .kill_i     (kill_i),
        .out_valid_o(out_valid2),
        .out_ready_i(out_ready_i),
        .result_o   (result2),
        .busy_o     (busy2)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Accept one operation in cycle 0 and wait for both instances to finish.
    task automatic run_op(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat1, input int lat2,
                          input string name);
        int first1;
        int first2;
        first1 = -1;
        first2 = -1;
        checks++;
        if ({in_ready1, in_ready2} !== 2'b11) begin
            errors++;
            $display("FAIL %s in_ready before accept: got %b%b want 11", name, in_ready1, in_ready2);
        end
        op_i = op; op_a_i = a; op_b_i = b; in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        op_a_i = 32'hDEAD_BEEF; op_b_i = 32'h0000_0001; op_i = DIV_OP_REMU;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (first1 < 0 && out_valid1) first1 = cyc;
            if (first2 < 0 && out_valid2) first2 = cyc;
            if (first1 >= 0 && first2 >= 0) break;
            tick();
        end
        checks++;
        if (first1 !== lat1) begin
            errors++;
            $display("FAIL %s latency bpc1: got %0d want %0d", name, first1, lat1);
        end
        checks++;
        if (first2 !== lat2) begin
            errors++;
            $display("FAIL %s latency bpc2: got %0d want %0d", name, first2, lat2);
        end
        checks++;
        if (result1 !== exp) begin
            errors++;
            $display("FAIL %s result bpc1: got %h want %h", name, result1, exp);
        end
        checks++;
        if (result2 !== exp) begin
            errors++;
            $display("FAIL %s result bpc2: got %h want %h", name, result2, exp);
        end
    endtask

    task automatic handshake(input string name);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        checks++;
        if ({out_valid1, out_valid2, in_ready1, in_ready2} !== 4'b0011) begin
            errors++;
            $display("FAIL %s after handshake valid/ready: got %b%b/%b%b want 00/11",
                     name, out_valid1, out_valid2, in_ready1, in_ready2);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if ({in_ready1, out_valid1, busy1, in_ready2, out_valid2, busy2} !== 6'b100100 ||
            result1 !== 32'h0 || result2 !== 32'h0) begin
            errors++;
            $display("FAIL %s: got rdy/vld/busy %b%b%b %b%b%b res %h %h want 100 100 res 0 0",
                     name, in_ready1, out_valid1, busy1, in_ready2, out_valid2, busy2,
                     result1, result2);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; in_valid_i = 1'b0; kill_i = 1'b0; out_ready_i = 1'b0;
        op_i = DIV_OP_DIV; op_a_i = '0; op_b_i = '0;
        tick();
        tick();
        check_reset_values("reset");
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        run_op(DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 18, "divu_100_7");
        handshake("divu_100_7");
        run_op(DIV_OP_REMU, 32'd100, 32'd7, 32'd2, 34, 18, "remu_100_7");
        handshake("remu_100_7");
        run_op(DIV_OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, 18, "div_m100_7");
        handshake("div_m100_7");
        run_op(DIV_OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34, 18, "rem_m100_7");
        handshake("rem_m100_7");
        run_op(DIV_OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 18, "div_7_m2");
        handshake("div_7_m2");
        run_op(DIV_OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 18, "rem_7_m2");
        handshake("rem_7_m2");
        run_op(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 18, "divu_max_1");
        handshake("divu_max_1");
    endtask

    task automatic test_special();
        run_op(DIV_OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1, "divu_5_0");
        handshake("divu_5_0");
        run_op(DIV_OP_REM, 32'd5, 32'd0, 32'd5, 1, 1, "rem_5_0");
        handshake("rem_5_0");
        run_op(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1, "div_ovf");
        handshake("div_ovf");
        run_op(DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 1, "rem_ovf");
        handshake("rem_ovf");
    endtask

    task automatic test_early_term();
`ifdef IBEX_DIV_EARLY_TERM_EN
        run_op(DIV_OP_DIV, 32'hFFFF_FFFD, 32'd10, 32'h0, 1, 1, "div_m3_10");
        handshake("div_m3_10");
        run_op(DIV_OP_REM, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, 1, 1, "rem_m3_10");
        handshake("rem_m3_10");
`else
        run_op(DIV_OP_DIV, 32'hFFFF_FFFD, 32'd10, 32'h0, 34, 18, "div_m3_10");
        handshake("div_m3_10");
        run_op(DIV_OP_REM, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, 34, 18, "rem_m3_10");
        handshake("rem_m3_10");
`endif
    endtask

    task automatic test_kill();
        logic seen_valid;
        op_i = DIV_OP_DIVU; op_a_i = 32'd1000; op_b_i = 32'd3; in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        repeat (9) tick();
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
        checks++;
        if ({in_ready1, in_ready2, out_valid1, out_valid2} !== 4'b1100) begin
            errors++;
            $display("FAIL kill_calc rdy/vld: got %b%b/%b%b want 11/00",
                     in_ready1, in_ready2, out_valid1, out_valid2);
        end
        // kill_i in IDLE must block acceptance.
        kill_i = 1'b1; in_valid_i = 1'b1;
        tick();
        kill_i = 1'b0; in_valid_i = 1'b0;
        checks++;
        if ({busy1, busy2} !== 2'b00) begin
            errors++;
            $display("FAIL kill_idle busy: got %b%b want 00", busy1, busy2);
        end
        seen_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid1 || out_valid2) seen_valid = 1'b1;
            tick();
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            errors++;
            $display("FAIL kill_no_valid: got %b want 0", seen_valid);
        end
        run_op(DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 34, 18, "divu_9_3");
        handshake("divu_9_3");
    endtask

    task automatic test_done_hold();
        run_op(DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 18, "hold_divu");
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({out_valid1, out_valid2} !== 2'b11 || result1 !== 32'd14 || result2 !== 32'd14) begin
                errors++;
                $display("FAIL hold_stable cycle %0d: got vld %b%b res %h %h want 11 res 0000000e",
                         i, out_valid1, out_valid2, result1, result2);
            end
        end
        handshake("hold_divu");
        // kill concurrent with out_ready in DONE: back to IDLE, result kept.
        run_op(DIV_OP_REMU, 32'd100, 32'd7, 32'd2, 34, 18, "kill_done");
        kill_i = 1'b1; out_ready_i = 1'b1;
        tick();
        kill_i = 1'b0; out_ready_i = 1'b0;
        checks++;
        if ({out_valid1, out_valid2, in_ready1, in_ready2} !== 4'b0011 ||
            result1 !== 32'd2 || result2 !== 32'd2) begin
            errors++;
            $display("FAIL kill_done: got vld %b%b rdy %b%b res %h %h want 00 11 res 00000002",
                     out_valid1, out_valid2, in_ready1, in_ready2, result1, result2);
        end
    endtask

    task automatic test_reset_mid_calc();
        op_i = DIV_OP_DIVU; op_a_i = 32'd1000; op_b_i = 32'd3; in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        repeat (5) tick();
        checks++;
        if ({busy1, busy2} !== 2'b11) begin
            errors++;
            $display("FAIL mid_calc busy: got %b%b want 11", busy1, busy2);
        end
        rst_ni = 1'b0;
        tick();
        check_reset_values("reset_mid_calc");
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_special();
        test_early_term();
        test_kill();
        test_done_hold();
        test_reset_mid_calc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
